// File: rtl/sqrt_pkg.sv
// Shared widths and step-operation decoding for the digit-free integer square root datapath.
// The root is found by subtracting successive odd numbers 1, 3, 5, ... from the radicand.
package sqrt_pkg;

    localparam int WIDTH  = 16;
    localparam int ROOT_W = WIDTH / 2;
    localparam int ODD_W  = WIDTH / 2 + 2;
    localparam int REM_W  = WIDTH + 1;
    localparam int CNT_W  = WIDTH / 2 + 1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_CAPTURE,
        OP_SUBTRACT,
        OP_INCREMENT
    } step_op_t;

    // A load always wins; without the pipe enable the step controls are don't-care.
    function automatic step_op_t decode_op(input logic wr_input,
                                           input logic en_pipe,
                                           input logic mux_root,
                                           input logic wr_square);
        step_op_t op;
        op = OP_HOLD;
        if (wr_input) begin
            op = OP_LOAD;
        end else if (en_pipe) begin
            if (mux_root) begin
                op = OP_CAPTURE;
            end else if (wr_square) begin
                op = OP_SUBTRACT;
            end else begin
                op = OP_INCREMENT;
            end
        end
        return op;
    endfunction

endpackage

// File: rtl/sqrt_datapath_if.sv
// Control/data bundle between the square-root sequencer (master) and the datapath (slave).
interface sqrt_datapath_if #(
    parameter int WIDTH = sqrt_pkg::WIDTH
);

    logic [WIDTH-1:0]   data_i;
    logic               wr_input_i;
    logic               en_pipe_i;
    logic               wr_square_i;
    logic               mux_root_i;
    logic               N_o;
    logic [WIDTH/2-1:0] root_o;
    logic               root_valid_o;

    modport master (
        output data_i, wr_input_i, en_pipe_i, wr_square_i, mux_root_i,
        input  N_o, root_o, root_valid_o
    );

    modport slave (
        input  data_i, wr_input_i, en_pipe_i, wr_square_i, mux_root_i,
        output N_o, root_o, root_valid_o
    );

endinterface

// File: rtl/sqrt_step_alu.sv
// Combinational next-value arithmetic for one iteration: remainder minus odd term,
// next odd term, and step count plus one.
module sqrt_step_alu #(
    parameter int WIDTH = sqrt_pkg::WIDTH
) (
    input  logic [WIDTH:0]     rem,
    input  logic [WIDTH/2+1:0] odd,
    input  logic [WIDTH/2:0]   cnt,
    output logic [WIDTH:0]     rem_next,
    output logic [WIDTH/2+1:0] odd_next,
    output logic [WIDTH/2:0]   cnt_next
);

    localparam int REM_BITS = WIDTH + 1;
    localparam int ODD_BITS = WIDTH / 2 + 2;
    localparam int CNT_BITS = WIDTH / 2 + 1;

    // The remainder is two's complement; its MSB becomes the "went negative" flag.
    assign rem_next = rem - REM_BITS'(odd);
    assign odd_next = odd + ODD_BITS'(2);
    assign cnt_next = cnt + CNT_BITS'(1);

endmodule

// File: rtl/sqrt_datapath.sv
// Square-root datapath: holds remainder, odd term, step count and the captured root;
// an external sequencer steers it through load / subtract / increment / capture.
module sqrt_datapath #(
    parameter int WIDTH = sqrt_pkg::WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    sqrt_datapath_if.slave  bus
);

    import sqrt_pkg::*;

    localparam int ROOT_BITS = WIDTH / 2;
    localparam int ODD_BITS  = WIDTH / 2 + 2;
    localparam int REM_BITS  = WIDTH + 1;
    localparam int CNT_BITS  = WIDTH / 2 + 1;

    logic [REM_BITS-1:0]  rem_q;
    logic [ODD_BITS-1:0]  odd_q;
    logic [CNT_BITS-1:0]  cnt_q;
    logic [ROOT_BITS-1:0] root_q;
    logic                 valid_q;

    logic [REM_BITS-1:0]  rem_next;
    logic [ODD_BITS-1:0]  odd_next;
    logic [CNT_BITS-1:0]  cnt_next;

    step_op_t op;

    sqrt_step_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .rem      (rem_q),
        .odd      (odd_q),
        .cnt      (cnt_q),
        .rem_next (rem_next),
        .odd_next (odd_next),
        .cnt_next (cnt_next)
    );

    always_comb begin
        op = decode_op(bus.wr_input_i, bus.en_pipe_i, bus.mux_root_i, bus.wr_square_i);
    end

    // The step count overshoots the root by one, since N only rises on the first failing subtract.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            odd_q   <= ODD_BITS'(1);
            cnt_q   <= '0;
            root_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (op)
                OP_LOAD: begin
                    rem_q   <= REM_BITS'(bus.data_i);
                    odd_q   <= ODD_BITS'(1);
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                end
                OP_CAPTURE: begin
                    root_q  <= ROOT_BITS'(cnt_q - CNT_BITS'(1));
                    valid_q <= 1'b1;
                end
                OP_SUBTRACT: begin
                    rem_q <= rem_next;
                    cnt_q <= cnt_next;
                end
                OP_INCREMENT: begin
                    odd_q <= odd_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.N_o          = rem_q[REM_BITS-1];
    assign bus.root_o       = root_q;
    assign bus.root_valid_o = valid_q;

endmodule

// File: tb/tb_sqrt_datapath.sv
// Self-checking bench for sqrt_datapath: an integer reference model is compared every cycle,
// and whole square-root runs are checked against literal roots and a software integer square root.
module tb_sqrt_datapath;

    localparam int WIDTH  = 16;
    localparam int ROOT_W = WIDTH / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int errors = 0;
    int checks = 0;

    sqrt_datapath_if #(.WIDTH(WIDTH)) bus ();

    sqrt_datapath #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    longint m_rem   = 0;
    longint m_odd   = 1;
    longint m_cnt   = 0;
    longint m_root  = 0;
    bit     m_valid = 1'b0;
    bit     cmp_en  = 1'b0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: plain integer arithmetic following the load/capture/subtract/increment rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem   <= 0;
            m_odd   <= 1;
            m_cnt   <= 0;
            m_root  <= 0;
            m_valid <= 1'b0;
        end else if (bus.wr_input_i === 1'b1) begin
            m_rem   <= longint'(bus.data_i);
            m_odd   <= 1;
            m_cnt   <= 0;
            m_valid <= 1'b0;
        end else if (bus.en_pipe_i === 1'b1) begin
            if (bus.mux_root_i === 1'b1) begin
                m_root  <= (m_cnt - 1) & ((longint'(1) << ROOT_W) - 1);
                m_valid <= 1'b1;
            end else if (bus.wr_square_i === 1'b1) begin
                m_rem <= m_rem - m_odd;
                m_cnt <= m_cnt + 1;
            end else begin
                m_odd <= m_odd + 2;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            checkOutput("cyc N_o", longint'(bus.N_o), longint'(m_rem < 0));
            checkOutput("cyc root_o", longint'(bus.root_o), m_root);
            checkOutput("cyc root_valid_o", longint'(bus.root_valid_o), longint'(m_valid));
        end
    end

    function automatic int isqrt(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic applyStimulus(input logic wr_in, input logic en, input logic sq,
                                 input logic mr, input logic [WIDTH-1:0] x);
        bus.wr_input_i  = wr_in;
        bus.en_pipe_i   = en;
        bus.wr_square_i = sq;
        bus.mux_root_i  = mr;
        bus.data_i      = x;
        @(negedge clk);
    endtask

    // Sequencer: subtract, look at N, increment if still non-negative; optional 10-cycle stall.
    task automatic iterate(input int pause_after, input bit do_capture, output int subs);
        int limit;
        limit = (1 << ROOT_W) + 4;
        subs  = 0;
        for (int i = 0; i < limit; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
            subs++;
            if (subs == pause_after) begin
                repeat (10) applyStimulus(1'b0, 1'b0, 1'bx, 1'bx, '0);
            end
            if (bus.N_o) break;
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        end
        checkOutput("N_o reached within budget", longint'(bus.N_o), 1);
        if (do_capture) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
    endtask

    task automatic runRoot(input int x, input int exp_root, input int exp_subs, input int pause_after);
        int subs;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(x));
        checkOutput("valid cleared by load", longint'(bus.root_valid_o), 0);
        iterate(pause_after, 1'b1, subs);
        checkOutput("subtract count", subs, exp_subs);
        checkOutput("root_o", longint'(bus.root_o), exp_root);
        checkOutput("root_valid_o", longint'(bus.root_valid_o), 1);
    endtask

    initial begin
        int subs;
        int x;
        bus.wr_input_i  = 1'b0;
        bus.en_pipe_i   = 1'b0;
        bus.wr_square_i = 1'b0;
        bus.mux_root_i  = 1'b0;
        bus.data_i      = '0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset N_o", longint'(bus.N_o), 0);
        checkOutput("reset root_o", longint'(bus.root_o), 0);
        checkOutput("reset root_valid_o", longint'(bus.root_valid_o), 0);
        #20 rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);

        runRoot(0, 0, 1, 0);
        runRoot(16, 4, 5, 0);
        runRoot(15, 3, 4, 0);
        runRoot(65535, 255, 256, 0);
        runRoot(100, 10, 11, 2);

        // Asynchronous reset in the middle of a run, then a clean rerun.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(100));
        iterate(0, 1'b0, subs);
        checkOutput("N_o before reset", longint'(bus.N_o), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid-run reset N_o", longint'(bus.N_o), 0);
        checkOutput("mid-run reset root_o", longint'(bus.root_o), 0);
        checkOutput("mid-run reset root_valid_o", longint'(bus.root_valid_o), 0);
        #14 rst_n = 1'b1;
        @(negedge clk);
        runRoot(100, 10, 11, 0);

        // A load arriving together with a capture takes priority.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(16));
        iterate(0, 1'b0, subs);
        checkOutput("X=16 subtracts before clash", subs, 5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, WIDTH'(49));
        checkOutput("clash root_valid_o", longint'(bus.root_valid_o), 0);
        checkOutput("clash root_o held", longint'(bus.root_o), 10);
        checkOutput("clash N_o from new X", longint'(bus.N_o), 0);
        iterate(0, 1'b1, subs);
        checkOutput("X=49 subtracts", subs, 8);
        checkOutput("X=49 root_o", longint'(bus.root_o), 7);
        checkOutput("X=49 root_valid_o", longint'(bus.root_valid_o), 1);

        for (int i = 0; i < 20; i++) begin
            x = int'($urandom_range(0, (1 << WIDTH) - 1));
            runRoot(x, isqrt(x), isqrt(x) + 1, ((i % 4) == 0) ? 1 : 0);
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
